vga_timing_gen: RTL and testbench

- Generates the raster timing that display consumers such as the scope overlay, font and legend logic take in: blank, hsync, vsync, plus pixel coordinates and frame/line strobes.
- Default timing is 640x480@60 industry timing at a 25 MHz pixel rate, gated by a pixel clock enable.
- Sits at the top of the video path; all video consumers are clocked from the same clk and sample its registered outputs.

---
 rtl/vga_timing_pkg.sv | 25 ++
 rtl/vga_axis_counter.sv | 52 +++++
 rtl/vga_timing_gen.sv | 103 ++++++++++
 tb/tb_vga_timing_gen.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared raster constants for the video path: default 640x480@60 timing
// and the coordinate width every consumer of pixel_x/pixel_y agrees on.
package vga_timing_pkg;

    localparam int COORD_W = 10;
    localparam int MAX_TOTAL = 1 << COORD_W;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;

    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int DEF_H_TOTAL = axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int DEF_V_TOTAL = axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter plus decodes of the active
// region and sync window, used once for columns and once for lines.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inc_i,
    output logic [COORD_W-1:0] count_o,
    output logic               active_o,
    output logic               sync_window_o,
    output logic               wrap_o
);

    localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
    localparam logic [COORD_W-1:0] LAST       = COORD_W'(TOTAL - 1);
    localparam logic [COORD_W:0]   ACTIVE_END = (COORD_W+1)'(ACTIVE);
    localparam logic [COORD_W:0]   SYNC_START = (COORD_W+1)'(ACTIVE + FP);
    localparam logic [COORD_W:0]   SYNC_END   = (COORD_W+1)'(ACTIVE + FP + SYNC);

    logic [COORD_W-1:0] count_q, count_d;
    logic [COORD_W:0]   next_ext;

    always_comb begin
        count_d = count_q;
        if (inc_i) begin
            count_d = (count_q == LAST) ? '0 : count_q + COORD_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Decodes look at the value being loaded, so a registered copy in the
    // parent lines up exactly with count_o.
    assign next_ext      = {1'b0, count_d};
    assign active_o      = next_ext < ACTIVE_END;
    assign sync_window_o = (next_ext >= SYNC_START) && (next_ext < SYNC_END);
    assign wrap_o        = inc_i && (count_q == LAST);
    assign count_o       = count_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source for the video path: registered blank/syncs aligned
// with the pixel coordinates, line/frame strobes and a frame counter.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_POL = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pix_en,
    output logic               blank,
    output logic               hsync,
    output logic               vsync,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
    output logic               line_start,
    output logic               frame_start,
    output logic [15:0]        frame_cnt
);

    localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_totals
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end

    logic h_active, h_sync_win, h_wrap;
    logic v_active, v_sync_win, v_wrap;
    logic v_inc;

    logic        blank_q, hsync_q, vsync_q, line_start_q, frame_start_q;
    logic [15:0] frame_cnt_q, frame_cnt_d;

    assign v_inc = pix_en & h_wrap;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_axis (
        .clk           (clk),
        .reset         (reset),
        .inc_i         (pix_en),
        .count_o       (pixel_x),
        .active_o      (h_active),
        .sync_window_o (h_sync_win),
        .wrap_o        (h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_axis (
        .clk           (clk),
        .reset         (reset),
        .inc_i         (v_inc),
        .count_o       (pixel_y),
        .active_o      (v_active),
        .sync_window_o (v_sync_win),
        .wrap_o        (v_wrap)
    );

    // A vertical wrap can only happen on a horizontal wrap, so it marks the frame end.
    assign frame_cnt_d = v_wrap ? frame_cnt_q + 16'd1 : frame_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blank_q       <= 1'b0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= 16'd0;
        end else begin
            blank_q       <= ~(h_active & v_active);
            hsync_q       <= h_sync_win ? SYNC_POL : ~SYNC_POL;
            vsync_q       <= v_sync_win ? SYNC_POL : ~SYNC_POL;
            line_start_q  <= h_wrap;
            frame_start_q <= v_wrap;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign blank       = blank_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a shrunken raster (16x8) so whole
// frames fit in a short run; a second instance covers active-low syncs.
module tb_vga_timing_gen;

    localparam int HA = 8;
    localparam int HF = 2;
    localparam int HS = 3;
    localparam int HB = 3;
    localparam int VA = 4;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    typedef struct packed {
        logic        blank;
        logic        hsync;
        logic        vsync;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        lineStart;
        logic        frameStart;
        logic [15:0] frameCnt;
        logic [15:0] frameCnt2;
    } expect_t;

    logic clk = 1'b0;
    logic reset;
    logic pixEn;

    logic        blankP, hsyncP, vsyncP, lineStartP, frameStartP;
    logic [9:0]  pixelXP, pixelYP;
    logic [15:0] frameCntP;
    logic        blankN, hsyncN, vsyncN, lineStartN, frameStartN;
    logic [9:0]  pixelXN, pixelYN;
    logic [15:0] frameCntN;

    expect_t scoreboard[$];
    int checks = 0;
    int errors = 0;
    int stepNum = 0;
    int mx, my;
    logic [15:0] mfc, mfc2;
    logic mls, mfs;
    int hsyncHigh, vsyncHigh, lineStarts, frameStarts, firstFrameStep;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b1)
    ) u_dut_pos (
        .clk(clk), .reset(reset), .pix_en(pixEn),
        .blank(blankP), .hsync(hsyncP), .vsync(vsyncP),
        .pixel_x(pixelXP), .pixel_y(pixelYP),
        .line_start(lineStartP), .frame_start(frameStartP),
        .frame_cnt(frameCntP)
    );

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b0)
    ) u_dut_neg (
        .clk(clk), .reset(reset), .pix_en(pixEn),
        .blank(blankN), .hsync(hsyncN), .vsync(vsyncN),
        .pixel_x(pixelXN), .pixel_y(pixelYN),
        .line_start(lineStartN), .frame_start(frameStartN),
        .frame_cnt(frameCntN)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s step=%0d observed=%0h expected=%0h", tag, stepNum, observed, expected);
        end
    endtask

    task automatic modelReset();
        mx = 0;
        my = 0;
        mfc = 16'd0;
        mfc2 = 16'd0;
        mls = 1'b0;
        mfs = 1'b0;
    endtask

    // Reference raster: advances the ideal beam position by one pixel per enabled edge.
    task automatic modelAdvance(input logic en);
        mls = 1'b0;
        mfs = 1'b0;
        if (en) begin
            if (mx == HT - 1) begin
                mls = 1'b1;
                mx = 0;
                if (my == VT - 1) begin
                    mfs = 1'b1;
                    my = 0;
                    mfc = mfc + 16'd1;
                    mfc2 = mfc2 + 16'd1;
                end else begin
                    my++;
                end
            end else begin
                mx++;
            end
        end
    endtask

    function automatic expect_t modelOutputs();
        expect_t e;
        e.blank      = !(mx < HA && my < VA);
        e.hsync      = (mx >= HA + HF) && (mx < HA + HF + HS);
        e.vsync      = (my >= VA + VF) && (my < VA + VF + VS);
        e.x          = 10'(mx);
        e.y          = 10'(my);
        e.lineStart  = mls;
        e.frameStart = mfs;
        e.frameCnt   = mfc;
        e.frameCnt2  = mfc2;
        return e;
    endfunction

    task automatic compareAll();
        expect_t e;
        if (scoreboard.size() == 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL scoreboard_empty step=%0d observed=0 expected=1", stepNum);
        end else begin
            e = scoreboard.pop_front();
            checkOutput("pixel_x", 32'(pixelXP), 32'(e.x));
            checkOutput("pixel_y", 32'(pixelYP), 32'(e.y));
            checkOutput("blank", 32'(blankP), 32'(e.blank));
            checkOutput("hsync", 32'(hsyncP), 32'(e.hsync));
            checkOutput("vsync", 32'(vsyncP), 32'(e.vsync));
            checkOutput("line_start", 32'(lineStartP), 32'(e.lineStart));
            checkOutput("frame_start", 32'(frameStartP), 32'(e.frameStart));
            checkOutput("frame_cnt", 32'(frameCntP), 32'(e.frameCnt));
            checkOutput("neg_pixel_x", 32'(pixelXN), 32'(e.x));
            checkOutput("neg_pixel_y", 32'(pixelYN), 32'(e.y));
            checkOutput("neg_blank", 32'(blankN), 32'(e.blank));
            checkOutput("neg_hsync", 32'(hsyncN), 32'(!e.hsync));
            checkOutput("neg_vsync", 32'(vsyncN), 32'(!e.vsync));
            checkOutput("neg_line_start", 32'(lineStartN), 32'(e.lineStart));
            checkOutput("neg_frame_start", 32'(frameStartN), 32'(e.frameStart));
            checkOutput("neg_frame_cnt", 32'(frameCntN), 32'(e.frameCnt2));
        end
    endtask

    // One clk: drive pix_en, queue what the raster must show after the edge, then compare.
    task automatic applyStimulus(input logic en);
        pixEn = en;
        modelAdvance(en);
        scoreboard.push_back(modelOutputs());
        @(posedge clk);
        #1;
        stepNum++;
        if (hsyncP) hsyncHigh++;
        if (vsyncP) vsyncHigh++;
        if (lineStartP) lineStarts++;
        if (frameStartP) begin
            frameStarts++;
            if (firstFrameStep < 0) firstFrameStep = stepNum;
        end
        compareAll();
    endtask

    task automatic clearTallies();
        hsyncHigh = 0;
        vsyncHigh = 0;
        lineStarts = 0;
        frameStarts = 0;
        firstFrameStep = -1;
        stepNum = 0;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_pixel_x"}, 32'(pixelXP), 32'd0);
        checkOutput({tag, "_pixel_y"}, 32'(pixelYP), 32'd0);
        checkOutput({tag, "_blank"}, 32'(blankP), 32'd0);
        checkOutput({tag, "_hsync"}, 32'(hsyncP), 32'd0);
        checkOutput({tag, "_vsync"}, 32'(vsyncP), 32'd0);
        checkOutput({tag, "_line_start"}, 32'(lineStartP), 32'd0);
        checkOutput({tag, "_frame_start"}, 32'(frameStartP), 32'd0);
        checkOutput({tag, "_frame_cnt"}, 32'(frameCntP), 32'd0);
        checkOutput({tag, "_neg_hsync"}, 32'(hsyncN), 32'd1);
        checkOutput({tag, "_neg_vsync"}, 32'(vsyncN), 32'd1);
        checkOutput({tag, "_neg_frame_cnt"}, 32'(frameCntN), 32'd0);
    endtask

    initial begin
        int toWrap;
        reset = 1'b1;
        pixEn = 1'b1;
        modelReset();
        clearTallies();
        repeat (3) @(posedge clk);
        #1;
        checkResetState("reset_hold");
        reset = 1'b0;

        $display("[TB] two frames at full pixel rate");
        for (int i = 0; i < 2 * HT * VT; i++) applyStimulus(1'b1);
        checkOutput("hsync_clks_full", 32'(hsyncHigh), 32'(2 * VT * HS));
        checkOutput("vsync_clks_full", 32'(vsyncHigh), 32'(2 * VS * HT));
        checkOutput("line_starts_full", 32'(lineStarts), 32'(2 * VT));
        checkOutput("frame_starts_full", 32'(frameStarts), 32'd2);
        checkOutput("first_frame_step", 32'(firstFrameStep), 32'(HT * VT));

        $display("[TB] two frames with pix_en every other clk");
        clearTallies();
        for (int i = 0; i < 4 * HT * VT; i++) applyStimulus(1'(i % 2));
        checkOutput("hsync_clks_half", 32'(hsyncHigh), 32'(2 * 2 * VT * HS));
        checkOutput("line_starts_half", 32'(lineStarts), 32'(2 * VT));
        checkOutput("frame_starts_half", 32'(frameStarts), 32'd2);

        $display("[TB] random pix_en");
        for (int i = 0; i < 100; i++) applyStimulus(1'($urandom_range(1, 0)));

        $display("[TB] reset mid-frame");
        while (mx == 0 && my == 0) applyStimulus(1'b1);
        for (int i = 0; i < HT + 5; i++) applyStimulus(1'b1);
        reset = 1'b1;
        #1;
        modelReset();
        checkResetState("reset_async");
        @(posedge clk);
        #1;
        checkResetState("reset_held_edge");
        reset = 1'b0;
        clearTallies();
        for (int i = 0; i < HT * VT + 3; i++) applyStimulus(1'b1);
        checkOutput("restart_frame_step", 32'(firstFrameStep), 32'(HT * VT));
        checkOutput("restart_frame_starts", 32'(frameStarts), 32'd1);

        $display("[TB] frame_cnt wrap on active-low instance");
        pixEn = 1'b0;
        force u_dut_neg.frame_cnt_q = 16'hFFFF;
        mfc2 = 16'hFFFF;
        applyStimulus(1'b0);
        release u_dut_neg.frame_cnt_q;
        applyStimulus(1'b0);
        toWrap = (VT - 1 - my) * HT + (HT - 1 - mx) + 1;
        for (int i = 0; i < toWrap; i++) applyStimulus(1'b1);
        checkOutput("wrap_frame_start", 32'(frameStartN), 32'd1);
        checkOutput("wrap_frame_cnt", 32'(frameCntN), 32'd0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
